// File: rtl/audio_decim_gain.sv
// Audio decimator with volume scaling.
// Reads samples from an upstream FIFO and keeps the first of every DECIM samples.
// Each kept sample is multiplied by a latched signed volume word with BITS
// fractional bits. The product is requantized by truncation toward zero and
// written to a downstream FIFO.
// Optional feature: define AUDIO_DECIM_GAIN_SATURATE_EN to clamp out-of-range
// results to the signed DATA_WIDTH limits. Without it, out-of-range results
// wrap in two's complement.
module audio_decim_gain #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned BITS       = 10,
    parameter int unsigned DECIM      = 8,
    parameter int unsigned GAIN_WIDTH = 16
) (
    input  logic                  clock,
    input  logic                  reset,
    input  logic [GAIN_WIDTH-1:0] volume,
    input  logic [DATA_WIDTH-1:0] in_dout,
    input  logic                  in_empty,
    output logic                  in_rd_en,
    input  logic                  out_full,
    output logic [DATA_WIDTH-1:0] out_din,
    output logic                  out_wr_en
);

    localparam int unsigned PW    = DATA_WIDTH + GAIN_WIDTH;
    localparam int unsigned CNT_W = (DECIM > 1) ? $clog2(DECIM) : 1;

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DECIM - 1);
    // Added to negative products so the arithmetic shift rounds toward zero.
    localparam logic [PW-1:0]    BIAS     = PW'((64'd1 << BITS) - 64'd1);

    localparam logic [1:0] S_READ  = 2'd0;
    localparam logic [1:0] S_MULT  = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;

    logic [1:0]            state_q, state_d;
    logic [CNT_W-1:0]      count_q, count_d;
    logic [DATA_WIDTH-1:0] sample_q, sample_d;
    logic [GAIN_WIDTH-1:0] vol_q, vol_d;
    logic [PW-1:0]         prod_q, prod_d;

    logic                  rd_fire;
    logic                  wr_fire;
    logic signed [PW-1:0]  sample_ext;
    logic signed [PW-1:0]  vol_ext;
    logic signed [PW-1:0]  prod_biased;
    logic signed [PW-1:0]  requant;
    logic [DATA_WIDTH-1:0] result;

    // FIFO strobes; both are held low while reset is asserted.
    assign in_rd_en  = !reset && (state_q == S_READ) && !in_empty;
    assign out_wr_en = !reset && (state_q == S_WRITE) && !out_full;
    assign rd_fire   = in_rd_en;
    assign wr_fire   = out_wr_en;

    // Sign-extend both operands to product width before multiplying.
    assign sample_ext = {{GAIN_WIDTH{sample_q[DATA_WIDTH-1]}}, sample_q};
    assign vol_ext    = {{DATA_WIDTH{vol_q[GAIN_WIDTH-1]}}, vol_q};

    // Next-state logic for the read / multiply / write sequence.
    always_comb begin
        state_d  = state_q;
        count_d  = count_q;
        sample_d = sample_q;
        vol_d    = vol_q;
        prod_d   = prod_q;
        unique case (state_q)
            S_READ: begin
                if (rd_fire) begin
                    count_d = (count_q == CNT_LAST) ? '0 : count_q + CNT_W'(1);
                    if (count_q == '0) begin
                        sample_d = in_dout;
                        vol_d    = volume;
                        state_d  = S_MULT;
                    end
                end
            end
            S_MULT: begin
                prod_d  = sample_ext * vol_ext;
                state_d = S_WRITE;
            end
            S_WRITE: begin
                if (wr_fire) begin
                    state_d = S_READ;
                end
            end
            default: begin
                state_d = S_READ;
            end
        endcase
    end

    // Requantize: divide by 2^BITS, truncating toward zero.
    always_comb begin
        prod_biased = $signed(prod_q);
        if (prod_q[PW-1]) begin
            prod_biased = $signed(prod_q + BIAS);
        end
        requant = prod_biased >>> BITS;
    end

`ifdef AUDIO_DECIM_GAIN_SATURATE_EN
    logic [GAIN_WIDTH:0] requant_top;
    logic                requant_ovf;

    // The result fits only when all bits above the output sign bit match it.
    assign requant_top = requant[PW-1:DATA_WIDTH-1];
    assign requant_ovf = !((&requant_top) || !(|requant_top));

    // Clamp out-of-range results to the nearest representable value.
    always_comb begin
        result = requant[DATA_WIDTH-1:0];
        if (requant_ovf) begin
            result = requant[PW-1] ? {1'b1, {(DATA_WIDTH-1){1'b0}}}
                                   : {1'b0, {(DATA_WIDTH-1){1'b1}}};
        end
    end
`else
    logic unused_requant_top;

    // Out-of-range results wrap; the upper requantized bits are dropped.
    assign unused_requant_top = ^requant[PW-1:DATA_WIDTH];
    assign result             = requant[DATA_WIDTH-1:0];
`endif

    // out_din follows the registered product, so it holds while backpressured.
    assign out_din = result;

    // State registers with asynchronous active-high reset.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= S_READ;
            count_q  <= '0;
            sample_q <= '0;
            vol_q    <= '0;
            prod_q   <= '0;
        end else begin
            state_q  <= state_d;
            count_q  <= count_d;
            sample_q <= sample_d;
            vol_q    <= vol_d;
            prod_q   <= prod_d;
        end
    end

endmodule

// File: tb/tb_audio_decim_gain.sv
// Directed self-checking bench for audio_decim_gain with default parameters.
// Inputs change just after the falling edge; outputs are checked 1 ns later.
module tb_audio_decim_gain;

    logic        clock;
    logic        reset;
    logic [15:0] volume;
    logic [31:0] in_dout;
    logic        in_empty;
    logic        in_rd_en;
    logic        out_full;
    logic [31:0] out_din;
    logic        out_wr_en;

    int vectors    = 0;
    int miscompares = 0;
    int overlaps   = 0;

    audio_decim_gain dut (
        .clock     (clock),
        .reset     (reset),
        .volume    (volume),
        .in_dout   (in_dout),
        .in_empty  (in_empty),
        .in_rd_en  (in_rd_en),
        .out_full  (out_full),
        .out_din   (out_din),
        .out_wr_en (out_wr_en)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) begin
        if (in_rd_en && out_wr_en) overlaps++;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, required $finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reads 7 discarded zeros so the decimation phase returns to count 0.
    task automatic fill7();
        in_dout  = 32'd0;
        in_empty = 1'b0;
        repeat (7) @(negedge clock);
        in_empty = 1'b1;
    endtask

    // One kept sample at count 0, checked through multiply and write.
    task automatic run_group(input string tag, input logic [31:0] din,
                             input logic [15:0] vol, input logic [31:0] exp);
        in_dout  = din;
        volume   = vol;
        in_empty = 1'b0;
        #1 check({tag, "_rd"}, {31'd0, in_rd_en}, 32'd1);
        @(negedge clock);
        in_empty = 1'b1;
        #1 check({tag, "_mult_wr"}, {31'd0, out_wr_en}, 32'd0);
        @(negedge clock);
        #1 check({tag, "_wr"}, {31'd0, out_wr_en}, 32'd1);
        check({tag, "_val"}, out_din, exp);
        @(negedge clock);
        fill7();
    endtask

    int idx;
    int wr_seen;
    logic rd;

    initial begin
        reset    = 1'b1;
        volume   = 16'd1024;
        in_dout  = 32'd5;
        in_empty = 1'b0;
        out_full = 1'b0;

        // Reset state.
        @(negedge clock);
        #1 check("rst_rd_en", {31'd0, in_rd_en}, 32'd0);
        check("rst_wr_en", {31'd0, out_wr_en}, 32'd0);
        check("rst_dout", out_din, 32'd0);
        reset    = 1'b0;
        in_empty = 1'b1;
        @(negedge clock);

        // Unity gain, inputs 0..15: writes 0 and 8, two clocks after each kept read.
        idx     = 0;
        wr_seen = 0;
        volume  = 16'd1024;
        for (int c = 0; c < 30; c++) begin
            in_dout  = idx;
            in_empty = (idx >= 16);
            #1;
            if (out_wr_en) begin
                wr_seen++;
                if (wr_seen == 1) begin
                    check("unity_t0", c, 32'd2);
                    check("unity_v0", out_din, 32'd0);
                end else if (wr_seen == 2) begin
                    check("unity_t1", c, 32'd12);
                    check("unity_v1", out_din, 32'd8);
                end
            end
            rd = in_rd_en;
            @(negedge clock);
            if (rd) idx++;
        end
        in_empty = 1'b1;
        check("unity_writes", wr_seen, 32'd2);
        check("unity_reads", idx, 32'd16);

        // Truncation toward zero at half gain.
        run_group("half_neg7", -32'sd7, 16'd512, -32'sd3);
        run_group("half_pos7", 32'd7, 16'd512, 32'd3);
        // Negative gain.
        run_group("neg_gain", 32'd5, 16'hFC00, -32'sd5);

        // Out-of-range results.
`ifdef AUDIO_DECIM_GAIN_SATURATE_EN
        run_group("sat_pos", 32'h4000_0000, 16'd4096, 32'h7FFF_FFFF);
        run_group("sat_neg", 32'hC000_0000, 16'd4096, 32'h8000_0000);
`else
        run_group("wrap_pos", 32'h4000_0000, 16'd4096, 32'h0000_0000);
        run_group("wrap_neg", 32'hC000_0000, 16'd4096, 32'h0000_0000);
`endif

        // Backpressure: 10 clocks of out_full in S_WRITE.
        in_dout  = 32'd77;
        volume   = 16'd1024;
        in_empty = 1'b0;
        out_full = 1'b1;
        @(negedge clock);
        @(negedge clock);
        for (int i = 0; i < 10; i++) begin
            #1 check("bp_wr", {31'd0, out_wr_en}, 32'd0);
            check("bp_rd", {31'd0, in_rd_en}, 32'd0);
            check("bp_val", out_din, 32'd77);
            @(negedge clock);
        end
        out_full = 1'b0;
        #1 check("bp_release_wr", {31'd0, out_wr_en}, 32'd1);
        check("bp_release_val", out_din, 32'd77);
        @(negedge clock);
        #1 check("bp_after_wr", {31'd0, out_wr_en}, 32'd0);
        fill7();

        // Reset during S_MULT aborts the pending write of 100.
        in_dout  = 32'd100;
        volume   = 16'd1024;
        in_empty = 1'b0;
        @(negedge clock);
        in_empty = 1'b1;
        reset    = 1'b1;
        #1 check("mrst_wr", {31'd0, out_wr_en}, 32'd0);
        check("mrst_dout", out_din, 32'd0);
        @(negedge clock);
        reset = 1'b0;
        wr_seen = 0;
        for (int i = 0; i < 3; i++) begin
            #1 if (out_wr_en) wr_seen++;
            @(negedge clock);
        end
        check("mrst_no_write", wr_seen, 32'd0);
        run_group("mrst_next", 32'd33, 16'd1024, 32'd33);

        // Volume changes after the kept read do not affect that sample.
        in_dout  = 32'd50;
        volume   = 16'd1024;
        in_empty = 1'b0;
        @(negedge clock);
        volume   = 16'd2048;
        in_empty = 1'b1;
        @(negedge clock);
        #1 check("vol_old_wr", {31'd0, out_wr_en}, 32'd1);
        check("vol_old_val", out_din, 32'd50);
        @(negedge clock);
        fill7();
        run_group("vol_new", 32'd50, 16'd2048, 32'd100);

        check("no_overlap", overlaps, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
